// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, memory vector locations, address width.
package cpu_pkg;
  localparam int ADDR_W = 8;
  localparam logic [ADDR_W-1:0] RESET_VEC_ADDR = 8'h00;
  localparam logic [ADDR_W-1:0] INT_VEC_ADDR   = 8'h01;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_INT  = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/ifid_reg.sv
// Generic pipeline register: invalidate beats hold, hold beats load.
module ifid_reg #(
  parameter int INSTR_W = 8,
  parameter int ADDR_W  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               hold,
  input  logic               inval,
  input  logic [INSTR_W-1:0] instr_d,
  input  logic [ADDR_W-1:0]  pc_plus1_d,
  output logic [INSTR_W-1:0] instr_q,
  output logic [ADDR_W-1:0]  pc_plus1_q,
  output logic               valid_q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_q    <= '0;
      pc_plus1_q <= '0;
      valid_q    <= 1'b0;
    end else if (inval) begin
      valid_q <= 1'b0;
    end else if (load && !hold) begin
      instr_q    <= instr_d;
      pc_plus1_q <= pc_plus1_d;
      valid_q    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC ownership, boot/interrupt vectoring, branch redirect, IF/ID capture.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int                ADDR_W         = cpu_pkg::ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_VEC_ADDR = cpu_pkg::RESET_VEC_ADDR,
  parameter logic [ADDR_W-1:0] INT_VEC_ADDR   = cpu_pkg::INT_VEC_ADDR
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] PC_Address,
  input  logic [7:0]        Instruction,
  input  logic              stall,
  input  logic              flush,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              interrupt,
  output logic [7:0]        ifid_instr,
  output logic [ADDR_W-1:0] ifid_pc_plus1,
  output logic              ifid_valid,
  output logic              int_ack,
`ifdef FETCH_PERF_EN
  output logic [15:0]       perf_fetch_cnt,
  output logic [15:0]       perf_stall_cnt,
`endif
  output logic [ADDR_W-1:0] ret_pc
);

  fetch_state_t      state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, pc_inc, ret_pc_n;
  logic              int_pend, pend_clr, ack_n;
  logic              ld, hold, inval, stall_evt;

  assign pc_inc = pc + ADDR_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_BOOT;
      pc       <= '0;
      int_pend <= 1'b0;
      int_ack  <= 1'b0;
      ret_pc   <= '0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      int_pend <= interrupt | (int_pend & ~pend_clr);
      int_ack  <= ack_n;
      ret_pc   <= ret_pc_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    ret_pc_n   = ret_pc;
    pend_clr   = 1'b0;
    ack_n      = 1'b0;
    ld         = 1'b0;
    hold       = 1'b0;
    inval      = 1'b0;
    stall_evt  = 1'b0;
    PC_Address = pc;
    case (state)
      S_BOOT: begin
        PC_Address = RESET_VEC_ADDR;
        pc_n       = ADDR_W'(Instruction);
        inval      = 1'b1;
        state_n    = S_RUN;
      end
      S_INT: begin
        // Vector fetch wins over any branch or stall in this cycle.
        PC_Address = INT_VEC_ADDR;
        pc_n       = ADDR_W'(Instruction);
        ack_n      = 1'b1;
        pend_clr   = 1'b1;
        inval      = 1'b1;
        state_n    = S_RUN;
      end
      S_RUN: begin
        if (branch_taken) begin
          pc_n  = branch_target;
          inval = 1'b1;
        end else if (flush) begin
          pc_n  = pc_inc;
          inval = 1'b1;
        end else if (int_pend && !stall) begin
          // The byte at pc is dropped and refetched on return via ret_pc.
          ret_pc_n = pc;
          inval    = 1'b1;
          state_n  = S_INT;
        end else if (stall) begin
          hold      = 1'b1;
          stall_evt = 1'b1;
        end else begin
          ld   = 1'b1;
          pc_n = pc_inc;
        end
      end
      default: state_n = S_BOOT;
    endcase
  end

  ifid_reg #(.INSTR_W(8), .ADDR_W(ADDR_W)) u_ifid (
    .clk        (clk),
    .rst        (rst),
    .load       (ld),
    .hold       (hold),
    .inval      (inval),
    .instr_d    (Instruction),
    .pc_plus1_d (pc_inc),
    .instr_q    (ifid_instr),
    .pc_plus1_q (ifid_pc_plus1),
    .valid_q    (ifid_valid)
  );

`ifdef FETCH_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (ld)        perf_fetch_cnt <= sat_inc(perf_fetch_cnt);
      if (stall_evt) perf_stall_cnt <= sat_inc(perf_stall_cnt);
    end
  end
`else
  logic unused_evt;
  assign unused_evt = stall_evt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot, stall, branch, interrupt, wrap, flush, async reset.
module tb_fetch_stage;
  logic       clk;
  logic       rst;
  logic [7:0] PC_Address;
  logic [7:0] Instruction;
  logic       stall, flush, branch_taken, interrupt;
  logic [7:0] branch_target;
  logic [7:0] ifid_instr, ifid_pc_plus1, ret_pc;
  logic       ifid_valid, int_ack;
  logic [7:0] mem [256];
  int checks = 0;
  int passed = 0;
  int fails  = 0;

  assign Instruction = mem[PC_Address];

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .PC_Address    (PC_Address),
    .Instruction   (Instruction),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .interrupt     (interrupt),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus1 (ifid_pc_plus1),
    .ifid_valid    (ifid_valid),
    .int_ack       (int_ack),
    .ret_pc        (ret_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; stall = 0; flush = 0; branch_taken = 0; branch_target = 8'h00; interrupt = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h10; mem[8'h01] = 8'h60;
    mem[8'h10] = 8'hA1; mem[8'h11] = 8'hA2; mem[8'h12] = 8'hA3;
    mem[8'h14] = 8'hC4; mem[8'h40] = 8'h55; mem[8'h60] = 8'hB0; mem[8'hFF] = 8'hEE;

    #12;
    check("rst_pc_addr", PC_Address, 8'h00);
    check("rst_valid", ifid_valid, 1'b0);
    check("rst_instr", ifid_instr, 8'h00);
    check("rst_pcp1", ifid_pc_plus1, 8'h00);
    check("rst_ack", int_ack, 1'b0);
    check("rst_retpc", ret_pc, 8'h00);

    // Boot
    rst = 1'b1;
    check("boot_addr", PC_Address, 8'h00);
    step();
    check("boot1_addr", PC_Address, 8'h10);
    check("boot1_valid", ifid_valid, 1'b0);
    step();
    check("boot2_addr", PC_Address, 8'h11);
    check("boot2_valid", ifid_valid, 1'b1);
    check("boot2_instr", ifid_instr, 8'hA1);
    check("boot2_pcp1", ifid_pc_plus1, 8'h11);
    step();
    check("boot3_addr", PC_Address, 8'h12);
    check("boot3_instr", ifid_instr, 8'hA2);

    // Stall two cycles at PC=12
    stall = 1;
    for (int k = 0; k < 2; k++) begin
      step();
      check("stall_addr", PC_Address, 8'h12);
      check("stall_instr", ifid_instr, 8'hA2);
      check("stall_valid", ifid_valid, 1'b1);
    end
    stall = 0;
    step();
    check("resume_instr", ifid_instr, 8'hA3);
    check("resume_pcp1", ifid_pc_plus1, 8'h13);
    check("resume_addr", PC_Address, 8'h13);

    // Branch with simultaneous stall
    branch_taken = 1; branch_target = 8'h40; stall = 1;
    step();
    branch_taken = 0; stall = 0;
    check("br_addr", PC_Address, 8'h40);
    check("br_valid", ifid_valid, 1'b0);
    step();
    check("br_instr", ifid_instr, 8'h55);
    check("br_pcp1", ifid_pc_plus1, 8'h41);
    check("br_valid2", ifid_valid, 1'b1);

    // Interrupt latched while fetching PC=14, taken at PC=15
    branch_taken = 1; branch_target = 8'h14;
    step();
    branch_taken = 0;
    interrupt = 1;
    step();
    interrupt = 0;
    check("irq_pre_addr", PC_Address, 8'h15);
    check("irq_pre_instr", ifid_instr, 8'hC4);
    step();
    check("irq_vec_addr", PC_Address, 8'h01);
    check("irq_retpc", ret_pc, 8'h15);
    check("irq_bub1", ifid_valid, 1'b0);
    check("irq_noack", int_ack, 1'b0);
    step();
    check("irq_handler_addr", PC_Address, 8'h60);
    check("irq_ack", int_ack, 1'b1);
    check("irq_bub2", ifid_valid, 1'b0);
    step();
    check("irq_ack_drop", int_ack, 1'b0);
    check("irq_h_instr", ifid_instr, 8'hB0);
    check("irq_h_valid", ifid_valid, 1'b1);
    check("irq_retpc_hold", ret_pc, 8'h15);

    // Wrap at FF
    branch_taken = 1; branch_target = 8'hFF;
    step();
    branch_taken = 0;
    check("wrap_addr_ff", PC_Address, 8'hFF);
    step();
    check("wrap_addr_00", PC_Address, 8'h00);
    check("wrap_instr", ifid_instr, 8'hEE);
    check("wrap_pcp1", ifid_pc_plus1, 8'h00);

    // Flush: invalidate, PC still advances
    flush = 1;
    step();
    flush = 0;
    check("flush_valid", ifid_valid, 1'b0);
    check("flush_addr", PC_Address, 8'h01);

    // Enter S_INT, then async reset between edges
    interrupt = 1;
    step();
    interrupt = 0;
    step();
    check("int2_addr", PC_Address, 8'h01);
    check("int2_retpc", ret_pc, 8'h02);
    #3;
    rst = 1'b0;
    #1;
    check("arst_addr", PC_Address, 8'h00);
    check("arst_retpc", ret_pc, 8'h00);
    check("arst_instr", ifid_instr, 8'h00);
    check("arst_pcp1", ifid_pc_plus1, 8'h00);
    check("arst_valid", ifid_valid, 1'b0);
    step();
    check("arst_noack", int_ack, 1'b0);
    rst = 1'b1;
    step();
    check("reboot_addr", PC_Address, 8'h10);
    step();
    check("reboot_noack", int_ack, 1'b0);
    check("reboot_pend_lost", PC_Address, 8'h11);
    check("reboot_instr", ifid_instr, 8'hA1);

    // Interrupt during S_BOOT; branch in vector cycle is dropped
    rst = 1'b0;
    #1;
    rst = 1'b1;
    interrupt = 1;
    step();
    interrupt = 0;
    check("bootirq_addr", PC_Address, 8'h10);
    step();
    check("bootirq_vec", PC_Address, 8'h01);
    check("bootirq_retpc", ret_pc, 8'h10);
    branch_taken = 1; branch_target = 8'h80;
    step();
    branch_taken = 0;
    check("bootirq_br_drop", PC_Address, 8'h60);
    check("bootirq_ack", int_ack, 1'b1);
    step();
    check("bootirq_instr", ifid_instr, 8'hB0);
    check("bootirq_pcp1", ifid_pc_plus1, 8'h61);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
